// File: rtl/div_issue_if.sv
// Bundle between the div issue sequencer and its neighbours: ex request, ctrl flush/stall,
// divider start/result and the register-file write port. master = surroundings, slave = sequencer.
interface div_issue_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               req_valid_i;
  logic [2:0]         op_i;
  logic [XLEN-1:0]    dividend_i;
  logic [XLEN-1:0]    divisor_i;
  logic [RADDR_W-1:0] reg_waddr_i;
  logic               flush_i;
  logic               div_start_o;
  logic [2:0]         div_op_o;
  logic [XLEN-1:0]    div_dividend_o;
  logic [XLEN-1:0]    div_divisor_o;
  logic [RADDR_W-1:0] div_reg_waddr_o;
  logic [XLEN-1:0]    div_result_i;
  logic               div_ready_i;
  logic               hold_flag_o;
  logic               reg_we_o;
  logic [RADDR_W-1:0] reg_waddr_o;
  logic [XLEN-1:0]    reg_wdata_o;

  modport master (
    output req_valid_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    output div_result_i, div_ready_i,
    input  div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_reg_waddr_o,
    input  hold_flag_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );

  modport slave (
    input  req_valid_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    input  div_result_i, div_ready_i,
    output div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_reg_waddr_o,
    output hold_flag_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );
endinterface

// File: rtl/div_issue.sv
// Sequences one DIV/DIVU/REM/REMU through the divider, stalls ex via hold_flag_o, writes rd in a one-cycle WB.
// DIV_RESULT_REUSE_EN: an identical repeat of the last completed divide skips the divider (IDLE->WB).
module div_issue #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  div_issue_if.slave  bus
);

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t             state;
  logic [2:0]         div_op;
  logic [XLEN-1:0]    div_dividend;
  logic [XLEN-1:0]    div_divisor;
  logic [RADDR_W-1:0] div_reg_waddr;
  logic               reg_we;
  logic [RADDR_W-1:0] reg_waddr;
  logic [XLEN-1:0]    reg_wdata;
  logic               is_div;
  logic               accept;
  logic               hit;

  assign is_div = (bus.op_i == INST_DIV)  || (bus.op_i == INST_DIVU) ||
                  (bus.op_i == INST_REM)  || (bus.op_i == INST_REMU);
  assign accept = (state == IDLE) && bus.req_valid_i && is_div && !bus.flush_i;

`ifdef DIV_RESULT_REUSE_EN
  // The div_* registers and reg_wdata already hold the last completed operation;
  // only a valid bit is needed on top of them.
  logic reuse_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reuse_vld <= 1'b0;
    end else if (state == BUSY) begin
      if (bus.flush_i)
        reuse_vld <= 1'b0;
      else if (bus.div_ready_i)
        reuse_vld <= 1'b1;
    end
  end

  assign hit = reuse_vld && (bus.op_i == div_op) &&
               (bus.dividend_i == div_dividend) && (bus.divisor_i == div_divisor);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      div_op        <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_reg_waddr <= '0;
      reg_we        <= 1'b0;
      reg_waddr     <= '0;
      reg_wdata     <= '0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            div_op        <= bus.op_i;
            div_dividend  <= bus.dividend_i;
            div_divisor   <= bus.divisor_i;
            div_reg_waddr <= bus.reg_waddr_i;
            if (hit) begin
              reg_we    <= |bus.reg_waddr_i;
              reg_waddr <= bus.reg_waddr_i;
              state     <= WB;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // Flush beats a result arriving in the same cycle.
          if (bus.flush_i) begin
            state <= IDLE;
          end else if (bus.div_ready_i) begin
            reg_wdata <= bus.div_result_i;
            reg_waddr <= div_reg_waddr;
            reg_we    <= |div_reg_waddr;
            state     <= WB;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Start is dropped in the ready cycle so the divider cannot relaunch.
  assign bus.div_start_o     = (state == BUSY) && !bus.div_ready_i;
  assign bus.hold_flag_o     = accept || (state == BUSY);
  assign bus.div_op_o        = div_op;
  assign bus.div_dividend_o  = div_dividend;
  assign bus.div_divisor_o   = div_divisor;
  assign bus.div_reg_waddr_o = div_reg_waddr;
  assign bus.reg_we_o        = reg_we;
  assign bus.reg_waddr_o     = reg_waddr;
  assign bus.reg_wdata_o     = reg_wdata;

endmodule

// File: tb/tb_div_issue.sv
// Randomized bench for div_issue: a behavioural divider plus a RISC-V division reference model.
module tb_div_issue;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
`ifdef DIV_RESULT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_issue_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

  div_issue #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int div_lat = 2;

  // Reuse bookkeeping: last completed divide
  bit         last_vld = 1'b0;
  logic [2:0] last_op;
  logic [31:0] last_a, last_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100:  if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return 32'($signed(a) / $signed(b));
      3'b101:  if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'b110:  if (b == 0) return a; else if (ovf) return 32'h0; else return 32'($signed(a) % $signed(b));
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Divider: ready div_lat cycles after start rises (one cycle for /0), aborts when start drops.
  initial begin
    bit          busy;
    int          rem;
    logic        st;
    logic [2:0]  o, lo;
    logic [31:0] a, b, la, lb;
    busy = 1'b0; rem = 0; lo = 3'b0; la = 0; lb = 0;
    bus.div_ready_i  = 1'b0;
    bus.div_result_i = '0;
    forever begin
      @(negedge clk);
      st = bus.div_start_o; o = bus.div_op_o; a = bus.div_dividend_o; b = bus.div_divisor_o;
      @(posedge clk); #1;
      if (bus.div_ready_i) begin
        bus.div_ready_i = 1'b0;
        busy = 1'b0;
      end else if (busy) begin
        if (!st) busy = 1'b0;
        else begin
          rem--;
          if (rem == 0) bus.div_ready_i = 1'b1;
        end
      end else if (st) begin
        busy = 1'b1; lo = o; la = a; lb = b;
        rem = (b == 0) ? 0 : div_lat - 1;
        if (rem == 0) bus.div_ready_i = 1'b1;
      end
      bus.div_result_i = bus.div_ready_i ? ref_div(lo, la, lb) : $urandom;
    end
  end

  // fmode: 0 none, 1 flush in BUSY at fcyc (0 = random), 2 flush during WB
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input int fmode_in, input int fcyc_in,
                       input logic [31:0] exp);
    bit hit, done;
    int wb_cyc, cyc, nbad, fmode, fcyc;
    hit    = REUSE && last_vld && (last_op == op) && (last_a == a) && (last_b == b);
    wb_cyc = hit ? 1 : ((b == 0) ? 3 : lat + 2);
    fmode  = (hit && fmode_in == 1) ? 0 : fmode_in;
    fcyc   = (fcyc_in != 0) ? fcyc_in : $urandom_range(1, wb_cyc - 1);
    div_lat = lat;
    bus.req_valid_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b;
    bus.reg_waddr_i = rd; bus.flush_i = 1'b0;
    #1;
    check("hold_accept", 32'(bus.hold_flag_o), 32'd1);
    check("start_c0", 32'(bus.div_start_o), 32'd0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0; bus.op_i = 3'($urandom); bus.dividend_i = $urandom;
    bus.divisor_i = $urandom; bus.reg_waddr_i = 5'($urandom);
    cyc = 1; done = 1'b0; nbad = 0;
    while (!done && cyc < 64) begin
      bus.flush_i = ((fmode == 1 && cyc == fcyc) || (fmode == 2 && cyc == wb_cyc));
      #1;
      if (cyc == 1) begin
        check("lat_op", 32'(bus.div_op_o), 32'(op));
        check("lat_a", bus.div_dividend_o, a);
        check("lat_b", bus.div_divisor_o, b);
        check("lat_rd", 32'(bus.div_reg_waddr_o), 32'(rd));
      end
      if (fmode == 1 && cyc == fcyc + 1) begin
        check("flush_start", 32'(bus.div_start_o), 32'd0);
        check("flush_hold", 32'(bus.hold_flag_o), 32'd0);
        check("flush_we", 32'(bus.reg_we_o), 32'd0);
        check("flush_keep", bus.div_dividend_o, a);
        done = 1'b1;
      end else if (fmode != 1 && cyc == wb_cyc) begin
        check("wb_we", 32'(bus.reg_we_o), 32'(rd != 0));
        check("wb_addr", 32'(bus.reg_waddr_o), 32'(rd));
        check("wb_data", bus.reg_wdata_o, exp);
        check("wb_hold", 32'(bus.hold_flag_o), 32'd0);
        check("wb_start", 32'(bus.div_start_o), 32'd0);
        done = 1'b1;
      end else begin
        if (bus.hold_flag_o !== 1'b1) nbad++;
        if (bus.reg_we_o !== 1'b0) nbad++;
        if (bus.div_start_o !== (cyc < wb_cyc - 1)) nbad++;
      end
      if (!done) begin @(posedge clk); #1; cyc++; end
    end
    check("inflight", 32'(nbad), 32'd0);
    if (!done) check("timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    if (fmode == 1) last_vld = 1'b0;
    else begin last_vld = 1'b1; last_op = op; last_a = a; last_b = b; end
  endtask

  task automatic do_ignored(input bit use_flush);
    bus.req_valid_i = 1'b1;
    bus.op_i = use_flush ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
    bus.dividend_i = $urandom; bus.divisor_i = $urandom; bus.reg_waddr_i = 5'($urandom_range(1, 31));
    bus.flush_i = use_flush;
    #1;
    check("ign_hold", 32'(bus.hold_flag_o), 32'd0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    check("ign_start", 32'(bus.div_start_o), 32'd0);
    check("ign_hold2", 32'(bus.hold_flag_o), 32'd0);
    check("ign_we", 32'(bus.reg_we_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ro, p_op;
    logic [31:0] ra, rb, p_a, p_b;
    int sel, fm;
    p_op = 3'b100; p_a = 0; p_b = 0;
    bus.req_valid_i = 1'b0; bus.op_i = '0; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.reg_waddr_i = '0; bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(bus.div_start_o), 32'd0);
    check("rst_hold", 32'(bus.hold_flag_o), 32'd0);
    check("rst_we", 32'(bus.reg_we_o), 32'd0);
    check("rst_waddr", 32'(bus.reg_waddr_o), 32'd0);
    check("rst_wdata", bus.reg_wdata_o, 32'd0);
    check("rst_op", 32'(bus.div_op_o), 32'd0);
    check("rst_a", bus.div_dividend_o, 32'd0);
    check("rst_b", bus.div_divisor_o, 32'd0);
    check("rst_rd", 32'(bus.div_reg_waddr_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'b101, 32'd100, 32'd7, 5'd5, 12, 0, 0, 32'd14);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 9, 0, 0, 32'hFFFF_FFFF);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 5, 0, 0, 32'hFFFF_FFFD);
    do_op(3'b100, 32'd1234, 32'd0, 5'd8, 2, 0, 0, 32'hFFFF_FFFF);
    do_op(3'b111, 32'd1234, 32'd0, 5'd9, 2, 0, 0, 32'h0000_04D2);
    do_op(3'b101, 32'd100, 32'd7, 5'd5, 20, 1, 10, 32'd14);
    do_op(3'b101, 32'd9, 32'd3, 5'd6, 7, 0, 0, 32'd3);
    do_op(3'b100, 32'd50, 32'd5, 5'd0, 6, 0, 0, 32'd10);
    do_ignored(1'b0);
    do_ignored(1'b1);
    do_op(3'b101, 32'd100, 32'd7, 5'd5, 10, 0, 0, 32'd14);
    do_op(3'b101, 32'd100, 32'd7, 5'd5, 10, 0, 0, 32'd14);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 4, 2, 0, 32'h8000_0000);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) do_ignored(1'($urandom_range(0, 1)));
      sel = $urandom_range(0, 5);
      ro = 3'(4 + $urandom_range(0, 3));
      ra = $urandom;
      case (sel)
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin ro = p_op; ra = p_a; rb = p_b; end
      sel = $urandom_range(0, 9);
      fm = (sel < 7) ? 0 : ((sel < 9) ? 1 : 2);
      do_op(ro, ra, rb, 5'($urandom_range(0, 31)), $urandom_range(2, 36), fm, 0, ref_div(ro, ra, rb));
      p_op = ro; p_a = ra; p_b = rb;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
